mult_sequencer: RTL and testbench

//   Iterative radix-2 shift-add multiplier sequencer serving MIPS mult/multu.

---
 rtl/mult_sequencer_if.sv | 28 ++
 rtl/mult_sequencer.sv | 120 ++++++++++++
 tb/tb_mult_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_sequencer_if.sv
// Handshake/bus bundle between the pipeline and the mult/multu sequencer.
// master = pipeline side (start, operands, mfhi/mflo requests), slave = sequencer.
interface mult_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             rd_hi_req;
    logic             rd_lo_req;
    logic             accept;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, sgn, srca, srcb, rd_hi_req, rd_lo_req,
        input  accept, busy, stall, done, hi, lo
    );

    modport slave (
        input  start, sgn, srca, srcb, rd_hi_req, rd_lo_req,
        output accept, busy, stall, done, hi, lo
    );
endinterface

// File: rtl/mult_sequencer.sv
// Iterative radix-2 shift-add multiplier for mult/multu, owning HI/LO.
// Ports: clk, reset (sync, active-low), bus (slave): start/sgn/srca/srcb,
//   rd_hi_req/rd_lo_req in; accept/busy/stall/done/hi/lo out.
module mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               busy;
    logic               accept;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0] prod;

    assign busy   = (state_q != IDLE);
    assign accept = bus.start & ~busy;

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        addend  = '0;
        sum     = '0;
        prod    = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // 0x80..0 negates to itself, which is 2^(W-1) unsigned.
                    mcand_d = (bus.sgn & bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
                    mplr_d  = (bus.sgn & bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;
                    neg_d   = bus.sgn & (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Add into the upper half with carry, then shift right so
                // the carry lands in the MSB of the accumulator.
                addend  = mplr_q[0] ? mcand_q : '0;
                sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
                acc_d   = {sum, acc_q[WIDTH-1:1]};
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                prod    = neg_q ? -acc_q : acc_q;
                hi_d    = prod[2*WIDTH-1:WIDTH];
                lo_d    = prod[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // A reader of HI/LO is younger than any starting or in-flight mult.
    assign bus.stall  = ((bus.rd_hi_req | bus.rd_lo_req) & (busy | bus.start))
                      | (bus.start & busy);
    assign bus.accept = accept;
    assign bus.busy   = busy;
    assign bus.done   = done_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: randomized and directed mult/multu
// operations checked against a 2*WIDTH-bit arithmetic reference.
module tb_mult_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mult_sequencer_if #(.WIDTH(W)) bus ();
    mult_sequencer #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    logic [W-1:0] hold_hi = '0;
    logic [W-1:0] hold_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
                                                input logic [W-1:0] b,
                                                input logic s);
        logic [2*W-1:0] xa;
        logic [2*W-1:0] xb;
        xa = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        xb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return xa * xb;
    endfunction

    // Monitor: every done must match the oldest expectation, on time;
    // while busy, HI/LO must still show the last committed product.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (bus.done) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected: got done=1 required 0 (cycle %0d)", cyc);
                end else begin
                    n_chk--;
                    e = sb.pop_front();
                    check("hi", bus.hi, e.hi);
                    check("lo", bus.lo, e.lo);
                    check("latency", cyc, e.due);
                    hold_hi = e.hi;
                    hold_lo = e.lo;
                end
            end else if (bus.busy) begin
                check("hi_atomic", bus.hi, hold_hi);
                check("lo_atomic", bus.lo, hold_lo);
            end
        end
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, output int acc_c);
        logic [2*W-1:0] p;
        bit got;
        int k;
        got = 0;
        k = 0;
        acc_c = -1;
        bus.start = 1'b1;
        bus.sgn   = s;
        bus.srca  = a;
        bus.srcb  = b;
        while (!got && k < 100) begin
            @(negedge clk);
            if (bus.accept) begin
                got = 1;
                acc_c = cyc;
                p = ref_mul(a, b, s);
                sb.push_back('{hi: p[2*W-1:W], lo: p[W-1:0], due: cyc + W + 2});
            end else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        check("accept_timeout", got, 1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.srca  = $urandom;
        bus.srcb  = $urandom;
        bus.sgn   = $urandom_range(0, 1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((sb.size() > 0 || bus.busy) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    function automatic logic [W-1:0] rand_op();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return {1'b1, {(W-1){1'b0}}};
        if (sel == 1) return '1;
        if (sel == 2) return '0;
        if (sel == 3) return W'($urandom_range(0, 15));
        return $urandom;
    endfunction

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int acc1;
        int acc2;
        int cnt;
        int k;
        bus.start     = 1'b0;
        bus.sgn       = 1'b0;
        bus.srca      = '0;
        bus.srcb      = '0;
        bus.rd_hi_req = 1'b0;
        bus.rd_lo_req = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_accept", bus.accept, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Unsigned 3*5 with busy duration and one-cycle done.
        issue(32'd3, 32'd5, 1'b0, acc1);
        cnt = 0;
        while (bus.busy && cnt < 100) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        check("busy_cycles", cnt, W + 1);
        check("done_rise", bus.done, 1);
        @(posedge clk);
        #1;
        check("done_width", bus.done, 0);
        wait_idle();

        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, acc1);
        wait_idle();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, acc1);
        wait_idle();
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, acc1);
        wait_idle();

        // Preload HI/LO = 7/8, then 2*3 with a waiting mflo.
        issue(32'd8, 32'hE000_0001, 1'b0, acc1);
        wait_idle();
        check("preload_hi", bus.hi, 7);
        issue(32'd2, 32'd3, 1'b0, acc1);
        bus.rd_lo_req = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.done && k < 100) begin
            check("mflo_stall", bus.stall, 1);
            check("mflo_old_lo", bus.lo, 8);
            @(negedge clk);
            k++;
        end
        check("mflo_done_stall", bus.stall, 0);
        check("mflo_new_lo", bus.lo, 6);
        @(posedge clk);
        #1;
        bus.rd_lo_req = 1'b0;
        wait_idle();

        // Start while busy: refused and stalled, then taken on first IDLE edge.
        issue(32'd7, 32'd9, 1'b1, acc1);
        bus.start = 1'b1;
        bus.sgn   = 1'b1;
        bus.srca  = 32'hFFFF_FFFD;
        bus.srcb  = 32'd11;
        @(negedge clk);
        check("busy_accept", bus.accept, 0);
        check("busy_stall", bus.stall, 1);
        @(posedge clk);
        #1;
        issue(32'hFFFF_FFFD, 32'd11, 1'b1, acc2);
        check("b2b_accept_cycle", acc2, acc1 + W + 2);
        wait_idle();

        // Reset mid-RUN abandons the operation.
        issue(32'd123, 32'd456, 1'b0, acc1);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        hold_hi = '0;
        hold_lo = '0;
        check("midrst_busy", bus.busy, 0);
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);
        cnt = 0;
        repeat (W + 4) begin
            @(posedge clk);
            #1;
            if (bus.done) cnt++;
        end
        check("midrst_no_done", cnt, 0);
        issue(32'h0001_0001, 32'h0000_FFFF, 1'b0, acc1);
        wait_idle();

        // Random traffic, sometimes back-to-back.
        for (int i = 0; i < 40; i++) begin
            issue(rand_op(), rand_op(), 1'($urandom_range(0, 1)), acc1);
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
